// File: rtl/i2c_bus_conditioner.sv
// Multi-channel I2C pad conditioner: input sync/glitch filter, registered open-drain
// drive, START/STOP detection, bus_busy tracking, arbitration-loss and SCL stuck-low detection.

module i2c_line_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic pad,
    output logic filt
);
    localparam int CNT_W = $clog2(FILT_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_LEN - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic [CNT_W-1:0]       cnt;

    // The toggle happens on the cycle the run of differing samples reaches FILT_LEN,
    // so pad-to-filt latency is SYNC_STAGES + FILT_LEN.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync <= '1;
            cnt  <= '0;
            filt <= 1'b1;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], pad};
            if (sync[SYNC_STAGES-1] == filt) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                filt <= ~filt;
                cnt  <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end
endmodule

module i2c_bus_conditioner #(
    parameter int N_CH        = 1,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4,
    parameter int IDLE_CYC    = 0,
    parameter int STUCK_CYC   = 1000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] scl_pad_i,
    input  logic [N_CH-1:0] sda_pad_i,
    input  logic [N_CH-1:0] scl_core_o,
    input  logic [N_CH-1:0] sda_core_o,
    input  logic [N_CH-1:0] arb_en,
    output logic [N_CH-1:0] scl_pad_o,
    output logic [N_CH-1:0] sda_pad_o,
    output logic [N_CH-1:0] scl_f,
    output logic [N_CH-1:0] sda_f,
    output logic [N_CH-1:0] start_det,
    output logic [N_CH-1:0] stop_det,
    output logic [N_CH-1:0] bus_busy,
    output logic [N_CH-1:0] arb_lost,
    output logic [N_CH-1:0] scl_stuck
);
    localparam int IDLE_W  = (IDLE_CYC > 0) ? $clog2(IDLE_CYC + 1) : 1;
    localparam int STUCK_W = $clog2(STUCK_CYC + 1);
    localparam logic [STUCK_W-1:0] STUCK_MAX  = STUCK_W'(STUCK_CYC);
    localparam logic [STUCK_W-1:0] STUCK_LAST = STUCK_W'(STUCK_CYC - 1);

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic scl_fl, sda_fl, scl_q, sda_q;
        logic scl_drv, sda_drv;
        logic start_r, stop_r, busy_r, arb_r, stuck_r;
        logic start_c, stop_c, scl_rise, idle_clr;
        logic [STUCK_W-1:0] stuck_cnt;

        i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_scl_filt (
            .clk(clk), .reset(reset), .pad(scl_pad_i[c]), .filt(scl_fl)
        );
        i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_sda_filt (
            .clk(clk), .reset(reset), .pad(sda_pad_i[c]), .filt(sda_fl)
        );

        // Requiring SCL high both before and after keeps a simultaneous SCL/SDA edge silent.
        assign start_c  = sda_q & ~sda_fl & scl_q & scl_fl;
        assign stop_c   = ~sda_q & sda_fl & scl_q & scl_fl;
        assign scl_rise = ~scl_q & scl_fl;

        if (IDLE_CYC > 0) begin : g_idle
            localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(IDLE_CYC);
            localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CYC - 1);
            logic [IDLE_W-1:0] idle_cnt;

            always_ff @(posedge clk) begin
                if (reset) begin
                    idle_cnt <= '0;
                end else if (!(scl_fl && sda_fl)) begin
                    idle_cnt <= '0;
                end else if (idle_cnt != IDLE_MAX) begin
                    idle_cnt <= idle_cnt + IDLE_W'(1);
                end
            end
            assign idle_clr = scl_fl & sda_fl & (idle_cnt == IDLE_LAST);
        end else begin : g_no_idle
            assign idle_clr = 1'b0;
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                scl_drv   <= 1'b1;
                sda_drv   <= 1'b1;
                scl_q     <= 1'b1;
                sda_q     <= 1'b1;
                start_r   <= 1'b0;
                stop_r    <= 1'b0;
                busy_r    <= 1'b0;
                arb_r     <= 1'b0;
                stuck_r   <= 1'b0;
                stuck_cnt <= '0;
            end else begin
                scl_drv <= scl_core_o[c];
                sda_drv <= sda_core_o[c];
                scl_q   <= scl_fl;
                sda_q   <= sda_fl;
                start_r <= start_c;
                stop_r  <= stop_c;
                // Released drive with a low bus on an SCL rise means someone else won.
                arb_r   <= arb_en[c] & sda_drv & ~sda_fl & scl_rise;
                if (start_c) begin
                    busy_r <= 1'b1;
                end else if (stop_c || idle_clr) begin
                    busy_r <= 1'b0;
                end
                if (scl_fl) begin
                    stuck_cnt <= '0;
                    stuck_r   <= 1'b0;
                end else if (stuck_cnt != STUCK_MAX) begin
                    stuck_cnt <= stuck_cnt + STUCK_W'(1);
                    if (stuck_cnt == STUCK_LAST) begin
                        stuck_r <= 1'b1;
                    end
                end
            end
        end

        assign scl_pad_o[c] = scl_drv;
        assign sda_pad_o[c] = sda_drv;
        assign scl_f[c]     = scl_fl;
        assign sda_f[c]     = sda_fl;
        assign start_det[c] = start_r;
        assign stop_det[c]  = stop_r;
        assign bus_busy[c]  = busy_r;
        assign arb_lost[c]  = arb_r;
        assign scl_stuck[c] = stuck_r;
    end
endmodule

// File: tb/tb_i2c_bus_conditioner.sv
// Directed bench for i2c_bus_conditioner: two channels on a modelled open-drain bus,
// hand-timed expectations for filter latency, START/STOP, arbitration, stuck and idle timeout.

module tb_i2c_bus_conditioner;
    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] ext_scl, ext_sda;
    logic [1:0] scl_core, sda_core, arb_en;
    logic [1:0] scl_pad_i, sda_pad_i;
    logic [1:0] scl_pad_o, sda_pad_o, scl_f, sda_f;
    logic [1:0] start_det, stop_det, bus_busy, arb_lost, scl_stuck;

    int n_vec = 0;
    int n_err = 0;
    int start_cnt[2] = '{0, 0};
    int stop_cnt[2]  = '{0, 0};
    int arb_cnt[2]   = '{0, 0};

    // Wired-AND bus: the pad sees low if either the external device or the DUT pulls.
    assign scl_pad_i = ext_scl & scl_pad_o;
    assign sda_pad_i = ext_sda & sda_pad_o;

    always #5 clk = ~clk;

    i2c_bus_conditioner #(
        .N_CH(2), .SYNC_STAGES(2), .FILT_LEN(4), .IDLE_CYC(50), .STUCK_CYC(100)
    ) dut (
        .clk(clk), .reset(reset),
        .scl_pad_i(scl_pad_i), .sda_pad_i(sda_pad_i),
        .scl_core_o(scl_core), .sda_core_o(sda_core), .arb_en(arb_en),
        .scl_pad_o(scl_pad_o), .sda_pad_o(sda_pad_o),
        .scl_f(scl_f), .sda_f(sda_f),
        .start_det(start_det), .stop_det(stop_det), .bus_busy(bus_busy),
        .arb_lost(arb_lost), .scl_stuck(scl_stuck)
    );

    always @(posedge clk) begin
        for (int c = 0; c < 2; c++) begin
            if (start_det[c] === 1'b1) start_cnt[c] <= start_cnt[c] + 1;
            if (stop_det[c] === 1'b1)  stop_cnt[c]  <= stop_cnt[c] + 1;
            if (arb_lost[c] === 1'b1)  arb_cnt[c]   <= arb_cnt[c] + 1;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        // Reset with the core pulling low and the pads low
        reset = 1'b1; scl_core = 2'b00; sda_core = 2'b00; arb_en = 2'b00;
        ext_scl = 2'b00; ext_sda = 2'b00;
        tick(1);
        check("rst_scl_pad_o", 32'(scl_pad_o), 32'h3);
        check("rst_sda_pad_o", 32'(sda_pad_o), 32'h3);
        check("rst_scl_f", 32'(scl_f), 32'h3);
        check("rst_sda_f", 32'(sda_f), 32'h3);
        check("rst_flags", 32'({start_det, stop_det, bus_busy, arb_lost, scl_stuck}), 32'h0);
        tick(2);
        scl_core = 2'b11; sda_core = 2'b11; ext_scl = 2'b11; ext_sda = 2'b11;
        tick(1);
        reset = 1'b0;
        tick(10);
        check("idle_f", 32'({scl_f, sda_f}), 32'hf);
        check("idle_busy", 32'(bus_busy), 32'h0);

        // Glitch rejection and filter latency on ch0 SDA
        ext_sda[0] = 1'b0; tick(3); ext_sda[0] = 1'b1; tick(10);
        check("glitch3_sda_f", 32'(sda_f[0]), 32'h1);
        check("glitch3_no_start", 32'(start_cnt[0]), 32'h0);
        ext_sda[0] = 1'b0; tick(4); ext_sda[0] = 1'b1; tick(1);
        check("low4_sda_f_t5", 32'(sda_f[0]), 32'h1);
        tick(1);
        check("low4_sda_f_t6", 32'(sda_f[0]), 32'h0);
        tick(1);
        check("low4_start_det", 32'(start_det[0]), 32'h1);
        tick(10);
        check("low4_stop_cnt", 32'(stop_cnt[0]), 32'h1);
        check("low4_busy", 32'(bus_busy[0]), 32'h0);

        // START, repeated START, STOP
        ext_sda[0] = 1'b0; tick(6);
        check("start_pre", 32'(start_det[0]), 32'h0);
        tick(1);
        check("start_det", 32'(start_det[0]), 32'h1);
        check("start_busy", 32'(bus_busy[0]), 32'h1);
        tick(1);
        check("start_pulse_end", 32'(start_det[0]), 32'h0);
        ext_scl[0] = 1'b0; tick(8);
        ext_sda[0] = 1'b1; tick(8);
        ext_scl[0] = 1'b1; tick(8);
        ext_sda[0] = 1'b0; tick(7);
        check("rstart_det", 32'(start_det[0]), 32'h1);
        check("rstart_busy", 32'(bus_busy[0]), 32'h1);
        tick(1);
        ext_sda[0] = 1'b1; tick(7);
        check("stop_det", 32'(stop_det[0]), 32'h1);
        check("stop_busy", 32'(bus_busy[0]), 32'h0);
        tick(1);
        check("stop_pulse_end", 32'(stop_det[0]), 32'h0);
        check("stop_cnt", 32'(stop_cnt[0]), 32'h2);

        // Arbitration loss: released drive, external low, SCL rises
        ext_scl[0] = 1'b0; tick(8);
        arb_en[0] = 1'b1; ext_sda[0] = 1'b0; tick(8);
        ext_scl[0] = 1'b1; tick(6);
        check("arb_pre", 32'(arb_lost[0]), 32'h0);
        tick(1);
        check("arb_lost", 32'(arb_lost[0]), 32'h1);
        tick(1);
        check("arb_pulse_end", 32'(arb_lost[0]), 32'h0);
        ext_scl[0] = 1'b0; tick(8);
        sda_core[0] = 1'b0; ext_sda[0] = 1'b1; tick(8);
        ext_scl[0] = 1'b1; tick(8);
        check("arb_core_low", 32'(arb_cnt[0]), 32'h1);
        ext_scl[0] = 1'b0; tick(8);
        arb_en[0] = 1'b0; sda_core[0] = 1'b1; ext_sda[0] = 1'b0; tick(8);
        ext_scl[0] = 1'b1; tick(8);
        check("arb_disabled", 32'(arb_cnt[0]), 32'h1);
        ext_scl[0] = 1'b0; tick(8);
        ext_sda[0] = 1'b1; tick(8);
        ext_scl[0] = 1'b1; tick(8);
        check("arb_events", 32'({start_cnt[0][3:0], stop_cnt[0][3:0]}), 32'h32);
        check("arb_no_stuck", 32'(scl_stuck), 32'h0);

        // SCL stuck low: scl_f falls 6 cycles after the pad, flag 100 cycles later
        ext_scl[0] = 1'b0; tick(105);
        check("stuck_99", 32'(scl_stuck[0]), 32'h0);
        tick(1);
        check("stuck_100", 32'(scl_stuck), 32'h1);
        ext_scl[0] = 1'b1; tick(7);
        check("stuck_clear", 32'(scl_stuck[0]), 32'h0);
        tick(8);

        // Channel independence, simultaneous edge, idle timeout
        ext_sda[0] = 1'b0; tick(7);
        check("ch0_start", 32'(start_det[0]), 32'h1);
        check("ch0_busy", 32'(bus_busy[0]), 32'h1);
        check("ch1_quiet", 32'({start_det[1], bus_busy[1], scl_f[1], sda_f[1]}), 32'h3);
        ext_scl[0] = 1'b0; tick(8);
        ext_scl[0] = 1'b1; ext_sda[0] = 1'b1; tick(55);
        check("idle_49_busy", 32'(bus_busy[0]), 32'h1);
        check("simul_no_event", 32'({start_cnt[0][3:0], stop_cnt[0][3:0]}), 32'h42);
        tick(1);
        check("idle_50_busy", 32'(bus_busy[0]), 32'h0);

        // Mid-transfer reset releases pads at once without a STOP
        ext_sda[0] = 1'b0; tick(7);
        check("mid_busy", 32'(bus_busy[0]), 32'h1);
        scl_core[0] = 1'b0; sda_core[0] = 1'b0; tick(1);
        check("drive_lat", 32'({scl_pad_o, sda_pad_o}), 32'ha);
        reset = 1'b1; tick(1);
        check("mid_rst_pads", 32'({scl_pad_o, sda_pad_o}), 32'hf);
        check("mid_rst_flags", 32'({bus_busy, stop_det}), 32'h0);
        ext_scl = 2'b11; ext_sda = 2'b11; scl_core = 2'b11; sda_core = 2'b11;
        tick(1);
        reset = 1'b0;
        tick(20);
        check("final_ch0", 32'({start_cnt[0][3:0], stop_cnt[0][3:0], arb_cnt[0][3:0]}), 32'h521);
        check("final_ch1", 32'({start_cnt[1][3:0], stop_cnt[1][3:0], arb_cnt[1][3:0]}), 32'h000);
        check("final_busy", 32'(bus_busy), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
